// File: rtl/gpio_input_conditioner.sv
// rtl/gpio_input_conditioner.sv - synchronized, debounced GPIO input word with sticky change mask
//
// Purpose: takes a raw asynchronous pin word, passes it through a SYNC_STAGES-deep
// synchronizer, and debounces the whole word as one unit. A new value is committed
// to gp_out only after DEBOUNCE_CYCLES consecutive cycles with no bit changing.
// Each commit that alters gp_out ORs the changed bits into a sticky mask and
// raises upd_pulse for one cycle.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous reset, active low
//   raw_in     in   WIDTH  raw pin word, asynchronous to clk
//   clr_chg    in   1      synchronous clear of chg_mask, active high
//   gp_out     out  WIDTH  debounced word
//   chg_mask   out  WIDTH  sticky mask of committed bit changes since the last clear
//   chg_flag   out  1      OR-reduction of chg_mask
//   upd_pulse  out  1      one-cycle pulse after each commit that changes gp_out
//
// SYNC_STAGES and DEBOUNCE_CYCLES must both be >= 2.

module gpio_input_conditioner #(
  parameter int WIDTH           = 32,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  input  logic             clr_chg,
  output logic [WIDTH-1:0] gp_out,
  output logic [WIDTH-1:0] chg_mask,
  output logic             chg_flag,
  output logic             upd_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, SETTLE} state_t;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] gp_q;
  logic [WIDTH-1:0] mask_q;
  logic [CNT_W-1:0] cnt_q;
  logic             upd_q;
  state_t           state_q;

  logic [WIDTH-1:0] commit_diff;
  logic [WIDTH-1:0] mask_kept;

  // Metastability synchronizer chain; s is the only value the FSM ever looks at.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Bits a commit would flip, and the mask contribution that survives a
  // coincident clear: clearing drops old bits but never the ones committing now.
  assign commit_diff = cand_q ^ gp_q;
  assign mask_kept   = clr_chg ? '0 : mask_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cand_q  <= '0;
      gp_q    <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (clr_chg) begin
        mask_q <= '0;
      end
      case (state_q)
        IDLE: begin
          if (s != gp_q) begin
            cand_q  <= s;
            cnt_q   <= '0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (s != cand_q) begin
            // Any bit moving restarts the window for the whole word.
            cand_q <= s;
            cnt_q  <= '0;
          end else if (cnt_q == CNT_LAST) begin
            // A bounce back to the old value lands here with commit_diff == 0:
            // gp_out is rewritten unchanged and no pulse is raised.
            gp_q    <= cand_q;
            mask_q  <= mask_kept | commit_diff;
            upd_q   <= |commit_diff;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gp_out    = gp_q;
  assign chg_mask  = mask_q;
  assign chg_flag  = |mask_q;
  assign upd_pulse = upd_q;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb/tb_gpio_input_conditioner.sv - directed self-checking bench for gpio_input_conditioner

module tb_gpio_input_conditioner;

  logic        clk;
  logic        rst;
  logic [31:0] raw_in;
  logic        clr_chg;
  logic [31:0] gp_out;
  logic [31:0] chg_mask;
  logic        chg_flag;
  logic        upd_pulse;

  int checks;
  int errors;
  int pulse_cnt;
  logic gp_moved;

  gpio_input_conditioner #(
    .WIDTH(32),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .raw_in(raw_in),
    .clr_chg(clr_chg),
    .gp_out(gp_out),
    .chg_mask(chg_mask),
    .chg_flag(chg_flag),
    .upd_pulse(upd_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges; outputs are sampled 1 time unit after each edge,
  // and every cycle with upd_pulse high is counted.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (upd_pulse === 1'b1) pulse_cnt++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    pulse_cnt = 0;
    rst       = 1'b1;
    raw_in    = 32'h0;
    clr_chg   = 1'b0;
    tick(2);

    // T1: asynchronous reset, then full-latency rise of every bit
    raw_in = 32'hFFFF_FFFF;
    rst    = 1'b0;
    #1;
    chk("t1_rst_gp", gp_out, 32'h0);
    chk("t1_rst_mask", chg_mask, 32'h0);
    chk("t1_rst_flag", {31'h0, chg_flag}, 32'h0);
    chk("t1_rst_pulse", {31'h0, upd_pulse}, 32'h0);
    tick(3);
    chk("t1_held_gp", gp_out, 32'h0);
    rst       = 1'b1;
    pulse_cnt = 0;
    tick(18);
    chk("t1_gp_edge18", gp_out, 32'h0);
    tick(1);
    chk("t1_gp_edge19", gp_out, 32'hFFFF_FFFF);
    chk("t1_pulse", {31'h0, upd_pulse}, 32'h1);
    chk("t1_mask", chg_mask, 32'hFFFF_FFFF);
    tick(1);
    chk("t1_pulse_gone", {31'h0, upd_pulse}, 32'h0);
    chk("t1_pulse_cnt", pulse_cnt, 32'd1);

    // Return to zero and clear the mask before T2
    raw_in = 32'h0;
    tick(25);
    chk("t2_pre_gp", gp_out, 32'h0);
    clr_chg = 1'b1;
    tick(1);
    clr_chg = 1'b0;
    chk("t2_pre_mask", chg_mask, 32'h0);

    // T2: clean step to 0xA5
    raw_in    = 32'h0000_00A5;
    pulse_cnt = 0;
    tick(18);
    chk("t2_gp_edge18", gp_out, 32'h0);
    tick(1);
    chk("t2_gp_edge19", gp_out, 32'h0000_00A5);
    chk("t2_flag", {31'h0, chg_flag}, 32'h1);
    chk("t2_mask", chg_mask, 32'h0000_00A5);
    tick(10);
    chk("t2_pulse_cnt", pulse_cnt, 32'd1);

    // Settle back to zero, clear mask
    raw_in = 32'h0;
    tick(25);
    clr_chg = 1'b1;
    tick(1);
    clr_chg = 1'b0;
    chk("t3_pre_gp", gp_out, 32'h0);

    // T3: bit0 toggles every 5 cycles for 40 cycles, then held high
    pulse_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      raw_in[0] = ~raw_in[0];
      tick(5);
      chk("t3_bounce_gp", gp_out, 32'h0);
    end
    raw_in[0] = 1'b1;
    tick(18);
    chk("t3_gp_edge18", gp_out, 32'h0);
    tick(1);
    chk("t3_gp_edge19", gp_out, 32'h1);
    tick(3);
    chk("t3_pulse_cnt", pulse_cnt, 32'd1);

    // T4: bit3 goes high for 6 cycles then back; nothing may change
    clr_chg = 1'b1;
    tick(1);
    clr_chg = 1'b0;
    pulse_cnt = 0;
    gp_moved  = 1'b0;
    raw_in = 32'h9;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      if (gp_out !== 32'h1) gp_moved = 1'b1;
    end
    raw_in = 32'h1;
    for (int k = 0; k < 40; k++) begin
      tick(1);
      if (gp_out !== 32'h1) gp_moved = 1'b1;
    end
    chk("t4_gp_moved", {31'h0, gp_moved}, 32'h0);
    chk("t4_pulse_cnt", pulse_cnt, 32'd0);
    chk("t4_mask", chg_mask, 32'h0);

    // T5: clear coincident with the commit of a bit4 change
    raw_in = 32'h0;
    tick(19);
    chk("t5_gp_zero", gp_out, 32'h0);
    chk("t5_mask_bit0", chg_mask, 32'h1);
    raw_in = 32'h10;
    tick(18);
    chk("t5_gp_edge18", gp_out, 32'h0);
    clr_chg = 1'b1;
    tick(1);
    clr_chg = 1'b0;
    chk("t5_gp_edge19", gp_out, 32'h10);
    chk("t5_mask_clr_commit", chg_mask, 32'h10);
    tick(2);
    clr_chg = 1'b1;
    tick(1);
    clr_chg = 1'b0;
    chk("t5_mask_clr_alone", chg_mask, 32'h0);
    chk("t5_flag_clr_alone", {31'h0, chg_flag}, 32'h0);

    // T6: reset 8 cycles into the settle of a step to 0x3
    raw_in = 32'h3;
    tick(8);
    chk("t6_gp_before_rst", gp_out, 32'h10);
    rst = 1'b0;
    #1;
    chk("t6_rst_gp", gp_out, 32'h0);
    chk("t6_rst_mask", chg_mask, 32'h0);
    chk("t6_rst_pulse", {31'h0, upd_pulse}, 32'h0);
    tick(1);
    rst = 1'b1;
    tick(18);
    chk("t6_gp_edge18", gp_out, 32'h0);
    tick(1);
    chk("t6_gp_edge19", gp_out, 32'h3);
    chk("t6_mask", chg_mask, 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
